// File: rtl/game_pkg.sv
// Shared types and defaults for the penalty-shootout referee.
package game_pkg;

  typedef enum logic [2:0] {
    G_START   = 3'd0,
    G_SHOOTER = 3'd1,
    G_KEEPER  = 3'd2,
    G_WINNER  = 3'd3,
    G_LOSER   = 3'd4
  } g_state;

  localparam int GAME_ROUNDS     = 5;
  localparam int END_HOLD_FRAMES = 120;
  localparam int SCORE_W         = 4;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + {{(SCORE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/shootout_judge.sv
// Combinational referee decision, evaluated on post-kick scores and kick counts.
module shootout_judge
  import game_pkg::*;
#(
  parameter int ROUNDS = GAME_ROUNDS
) (
  input  logic [SCORE_W-1:0] player_score,
  input  logic [SCORE_W-1:0] cpu_score,
  input  logic [SCORE_W-1:0] pk,
  input  logic [SCORE_W-1:0] ck,
  input  logic               is_shooter,
  output logic               win,
  output logic               lose
);

  // One extra bit so score + remaining kicks never wraps.
  localparam int W1 = SCORE_W + 1;

  logic [W1-1:0] ps_x, cs_x, pk_x, ck_x, rounds_x;
  logic          regulation;

  // Decide whether the match is settled after the kick just taken.
  always_comb begin
    ps_x       = {1'b0, player_score};
    cs_x       = {1'b0, cpu_score};
    pk_x       = {1'b0, pk};
    ck_x       = {1'b0, ck};
    rounds_x   = W1'(ROUNDS);
    regulation = (pk_x <= rounds_x) && (ck_x <= rounds_x);
    win        = 1'b0;
    lose       = 1'b0;
    if (regulation) begin
      if (ps_x > cs_x + (rounds_x - ck_x)) begin
        win = 1'b1;
      end else if (cs_x > ps_x + (rounds_x - pk_x)) begin
        lose = 1'b1;
      end
    end
    // A pair is only complete after the keeper kick, since the player kicks first.
    if (!is_shooter && (pk_x == ck_x) && (pk_x >= rounds_x)) begin
      if (ps_x > cs_x) begin
        win = 1'b1;
      end else if (cs_x > ps_x) begin
        lose = 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_state_ctl.sv
// Penalty-shootout referee FSM: game state, scores and per-kick start pulse.
//
// state     | meaning
// ----------+---------------------------------------------
// G_START   | title screen, waiting for a click
// G_SHOOTER | player is kicking
// G_KEEPER  | cpu is kicking, player keeps goal
// G_WINNER  | player won; click accepted after hold period
// G_LOSER   | player lost; click accepted after hold period
module game_state_ctl
  import game_pkg::*;
#(
  parameter int ROUNDS          = GAME_ROUNDS,
  parameter int END_HOLD_FRAMES = game_pkg::END_HOLD_FRAMES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_req,
  input  logic               frame_tick,
  input  logic               kick_done,
  input  logic               kick_goal,
  output g_state             game_state,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] cpu_score,
  output logic               kick_start
);

  localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(END_HOLD_FRAMES);

  g_state             state_q, state_d;
  logic [SCORE_W-1:0] ps_q, ps_d, cs_q, cs_d;
  logic [SCORE_W-1:0] pk_q, pk_d, ck_q, ck_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               kick_start_q, kick_start_d;

  logic [SCORE_W-1:0] ps_post, cs_post, pk_post, ck_post;
  logic               is_shooter, win, lose;

  // Values the counters would take if the current kick completes now.
  always_comb begin
    is_shooter = (state_q == G_SHOOTER);
    ps_post    = ps_q;
    cs_post    = cs_q;
    pk_post    = pk_q;
    ck_post    = ck_q;
    if (is_shooter) begin
      pk_post = sat_inc(pk_q);
      if (kick_goal) ps_post = sat_inc(ps_q);
    end else begin
      ck_post = sat_inc(ck_q);
      if (kick_goal) cs_post = sat_inc(cs_q);
    end
  end

  shootout_judge #(
    .ROUNDS(ROUNDS)
  ) u_judge (
    .player_score(ps_post),
    .cpu_score   (cs_post),
    .pk          (pk_post),
    .ck          (ck_post),
    .is_shooter  (is_shooter),
    .win         (win),
    .lose        (lose)
  );

  // Next-state, counter updates and kick_start request.
  always_comb begin
    state_d      = state_q;
    ps_d         = ps_q;
    cs_d         = cs_q;
    pk_d         = pk_q;
    ck_d         = ck_q;
    hold_d       = hold_q;
    kick_start_d = 1'b0;
    case (state_q)
      G_START: begin
        if (start_req) begin
          state_d      = G_SHOOTER;
          ps_d         = '0;
          cs_d         = '0;
          pk_d         = '0;
          ck_d         = '0;
          kick_start_d = 1'b1;
        end
      end
      G_SHOOTER, G_KEEPER: begin
        if (kick_done) begin
          ps_d = ps_post;
          cs_d = cs_post;
          pk_d = pk_post;
          ck_d = ck_post;
          if (win) begin
            state_d = G_WINNER;
            hold_d  = '0;
          end else if (lose) begin
            state_d = G_LOSER;
            hold_d  = '0;
          end else begin
            state_d      = is_shooter ? G_KEEPER : G_SHOOTER;
            kick_start_d = 1'b1;
          end
        end
      end
      G_WINNER, G_LOSER: begin
        // Registered hold count decides, so a same-cycle tick cannot unlock a click.
        if (start_req && (hold_q == HOLD_MAX)) begin
          state_d = G_START;
        end else if (frame_tick && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = G_START;
    endcase
  end

  // State, counters and kick_start register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= G_START;
      ps_q         <= '0;
      cs_q         <= '0;
      pk_q         <= '0;
      ck_q         <= '0;
      hold_q       <= '0;
      kick_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ps_q         <= ps_d;
      cs_q         <= cs_d;
      pk_q         <= pk_d;
      ck_q         <= ck_d;
      hold_q       <= hold_d;
      kick_start_q <= kick_start_d;
    end
  end

  assign game_state   = state_q;
  assign player_score = ps_q;
  assign cpu_score    = cs_q;
  assign kick_start   = kick_start_q;

endmodule

// File: tb/tb_game_state_ctl.sv
// Directed bench for the penalty-shootout referee.
module tb_game_state_ctl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_req = 1'b0;
  logic       frame_tick = 1'b0;
  logic       kick_done = 1'b0;
  logic       kick_goal = 1'b0;
  g_state     game_state;
  logic [3:0] player_score;
  logic [3:0] cpu_score;
  logic       kick_start;

  int n_chk = 0;
  int n_bad = 0;

  game_state_ctl #(
    .ROUNDS         (5),
    .END_HOLD_FRAMES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_req   (start_req),
    .frame_tick  (frame_tick),
    .kick_done   (kick_done),
    .kick_goal   (kick_goal),
    .game_state  (game_state),
    .player_score(player_score),
    .cpu_score   (cpu_score),
    .kick_start  (kick_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic goal);
    kick_done = 1'b1;
    kick_goal = goal;
    step();
    kick_done = 1'b0;
    kick_goal = 1'b0;
  endtask

  task automatic click();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic chk_state(input string tag, input g_state exp_s, input int exp_ks);
    chk({tag, "_state"}, int'(game_state), int'(exp_s));
    chk({tag, "_ks"}, int'(kick_start), exp_ks);
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    chk_state("rst", G_START, 0);
    chk("rst_ps", int'(player_score), 0);
    chk("rst_cs", int'(cpu_score), 0);

    // 2: start, kick_done ignored in START
    kick(1'b1);
    chk("start_ign_ps", int'(player_score), 0);
    chk_state("start_ign", G_START, 0);
    click();
    chk_state("start", G_SHOOTER, 1);
    step();
    chk("start_ks_off", int'(kick_start), 0);

    // 3: early win after cpu kick 3
    kick_goal = 1'b1;
    start_req = 1'b1;
    step();
    kick_goal = 1'b0;
    start_req = 1'b0;
    chk_state("ign_goal", G_SHOOTER, 0);
    chk("ign_goal_ps", int'(player_score), 0);
    kick(1'b1);
    chk_state("p1", G_KEEPER, 1);
    chk("p1_ps", int'(player_score), 1);
    kick(1'b0);
    chk_state("c1", G_SHOOTER, 1);
    kick(1'b1);
    kick(1'b0);
    kick(1'b1);
    chk_state("p3", G_KEEPER, 1);
    chk("p3_ps", int'(player_score), 3);
    kick(1'b0);
    chk_state("c3_win", G_WINNER, 0);
    chk("c3_cs", int'(cpu_score), 0);
    frames(4);
    click();
    chk_state("win_exit", G_START, 0);

    // 4: sudden death
    click();
    for (int r = 0; r < 5; r++) begin
      kick(1'b1);
      kick(1'b1);
    end
    chk_state("sd_entry", G_SHOOTER, 1);
    chk("sd_ps", int'(player_score), 5);
    chk("sd_cs", int'(cpu_score), 5);
    kick(1'b1);
    chk_state("sd_p", G_KEEPER, 1);
    kick(1'b0);
    chk_state("sd_win", G_WINNER, 0);
    chk("sd_ps_fin", int'(player_score), 6);
    chk("sd_cs_fin", int'(cpu_score), 5);
    frames(4);
    click();
    chk_state("sd_exit", G_START, 0);

    // 5: loss and end hold
    click();
    chk("new_game_ps", int'(player_score), 0);
    kick(1'b0);
    kick(1'b1);
    kick(1'b0);
    kick(1'b1);
    kick(1'b0);
    chk_state("l_p3", G_KEEPER, 1);
    kick(1'b1);
    chk_state("lose", G_LOSER, 0);
    chk("lose_cs", int'(cpu_score), 3);
    frames(3);
    click();
    chk_state("hold3", G_LOSER, 0);
    start_req  = 1'b1;
    frame_tick = 1'b1;
    step();
    start_req  = 1'b0;
    frame_tick = 1'b0;
    chk_state("hold_simul", G_LOSER, 0);
    click();
    chk_state("hold4", G_START, 0);

    // 6: reset mid-kick
    click();
    kick(1'b1);
    chk_state("mid_keeper", G_KEEPER, 1);
    rst       = 1'b1;
    kick_done = 1'b1;
    kick_goal = 1'b1;
    step();
    rst       = 1'b0;
    kick_done = 1'b0;
    kick_goal = 1'b0;
    chk_state("mid_rst", G_START, 0);
    chk("mid_rst_ps", int'(player_score), 0);
    chk("mid_rst_cs", int'(cpu_score), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
